// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, idle-high line.
// Samples the synchronised line at mid-bit from a cycle counter. Each byte is
// presented with a single-cycle data_valid strobe. A low stop bit gives a
// single-cycle frame_error strobe instead.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       synchronous reset, active-low
//   input_rx    asynchronous serial line (idle high)
//   data_byte   last correctly framed byte; holds until the next good frame
//   data_valid  one-cycle pulse: data_byte updated this cycle
//   frame_error one-cycle pulse: stop bit sampled low
//   busy        high whenever the receiver is not idle
module uart_rx #(
  parameter int unsigned clk_freq = 10000000,
  parameter int unsigned baudrate = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       input_rx,
  output logic [7:0] data_byte,
  output logic       data_valid,
  output logic       frame_error,
  output logic       busy
);

  localparam int unsigned CPB  = clk_freq / baudrate;
  localparam int unsigned HALF = CPB / 2;
  localparam logic [24:0] CPB_M1  = 25'(CPB - 1);
  localparam logic [24:0] HALF_M1 = 25'(HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t      state_q, state_d;
  logic        rx_meta_q, rx_s_q;
  logic [24:0] clk_count_q, clk_count_d;
  logic [2:0]  bit_index_q, bit_index_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_byte_q, data_byte_d;
  logic        data_valid_q, data_valid_d;
  logic        frame_error_q, frame_error_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q     <= 1'b1;
      rx_s_q        <= 1'b1;
      state_q       <= S_IDLE;
      clk_count_q   <= '0;
      bit_index_q   <= '0;
      shift_q       <= '0;
      data_byte_q   <= '0;
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      rx_meta_q     <= input_rx;
      rx_s_q        <= rx_meta_q;
      state_q       <= state_d;
      clk_count_q   <= clk_count_d;
      bit_index_q   <= bit_index_d;
      shift_q       <= shift_d;
      data_byte_q   <= data_byte_d;
      data_valid_q  <= data_valid_d;
      frame_error_q <= frame_error_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    clk_count_d   = clk_count_q + 25'd1;
    bit_index_d   = bit_index_q;
    shift_d       = shift_q;
    data_byte_d   = data_byte_q;
    data_valid_d  = 1'b0;
    frame_error_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        clk_count_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (clk_count_q == HALF_M1) begin
          clk_count_d = '0;
          if (!rx_s_q) begin
            state_d     = S_DATA;
            bit_index_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        // Counter restarts after every bit sample so each bit period is
        // measured from the previous sample point.
        if (clk_count_q == CPB_M1) begin
          clk_count_d = '0;
          shift_d     = {rx_s_q, shift_q[7:1]};
          bit_index_d = bit_index_q + 3'd1;
          if (bit_index_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (clk_count_q == CPB_M1) begin
          clk_count_d = '0;
          if (rx_s_q) begin
            data_byte_d  = shift_q;
            data_valid_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            frame_error_d = 1'b1;
            state_d       = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        // A held-low (break) line must go high before a new frame can start.
        clk_count_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: begin
        clk_count_d = '0;
        state_d     = S_IDLE;
      end
    endcase
  end

  assign data_byte   = data_byte_q;
  assign data_valid  = data_valid_q;
  assign frame_error = frame_error_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx at default parameters (CPB=86, HALF=43).
// The bench transmits frames itself and predicts, from the bit period it used,
// which line value each receiver sample point falls on and in which cycle the
// result strobe must appear. A per-cycle process compares the strobes and
// data_byte against those predictions; directed checks pin absolute timing.
module tb_uart_rx;

  localparam int CPB  = 10000000 / 115200;
  localparam int HALF = CPB / 2;

  logic       clk;
  logic       rst_n;
  logic       rx_line;
  logic [7:0] data_byte;
  logic       data_valid;
  logic       frame_error;
  logic       busy;

  uart_rx #(.clk_freq(10000000), .baudrate(115200)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .input_rx   (rx_line),
    .data_byte  (data_byte),
    .data_valid (data_valid),
    .frame_error(frame_error),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int         cyc;
    bit         valid;
    logic [7:0] data;
  } exp_t;

  exp_t       exq[$];
  logic [7:0] exp_byte = 8'h00;
  bit         chk_en   = 1'b0;
  int         rst_cyc  = -1;

  // Line value at offset 'off' cycles after the start edge of a frame sent
  // with bit period p (slot 0 = start bit, 1..8 data, 9 stop).
  function automatic bit line_at(input logic [7:0] d, input bit stop, input int p, input int off);
    int slot;
    slot = off / p;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return d[slot-1];
    if (slot == 9) return stop;
    return 1'b1;
  endfunction

  // Start edge driven in cycle n: two synchroniser cycles plus one to enter
  // START, then samples at HALF-1 and every CPB cycles after; each sample sees
  // the line value from two cycles earlier.
  function automatic exp_t predict(input int n, input logic [7:0] d, input bit stop, input int p);
    exp_t e;
    e.cyc  = n + 3 + HALF + 9 * CPB;
    e.data = '0;
    for (int k = 0; k < 8; k++)
      e.data[k] = line_at(d, stop, p, HALF + (k + 1) * CPB);
    e.valid = line_at(d, stop, p, HALF + 9 * CPB);
    return e;
  endfunction

  // ---------------- per-cycle compare ----------------
  int n_dv = 0, n_fe = 0;
  int last_dv_cyc = -1;
  bit busy_at_dv, busy_before_dv, prev_busy;

  always @(negedge clk) begin
    if (chk_en) begin
      bit exp_v, exp_fe;
      exp_v  = 1'b0;
      exp_fe = 1'b0;
      if (cyc == rst_cyc) begin
        exp_byte = 8'h00;
        check("busy_after_reset", busy, 1'b0);
      end
      while (exq.size() > 0 && exq[0].cyc < cyc) begin
        check("pulse_cycle", cyc, exq[0].cyc);
        void'(exq.pop_front());
      end
      if (exq.size() > 0 && exq[0].cyc == cyc) begin
        exp_v  = exq[0].valid;
        exp_fe = !exq[0].valid;
        if (exq[0].valid) exp_byte = exq[0].data;
        void'(exq.pop_front());
      end
      check("data_valid", data_valid, exp_v);
      check("frame_error", frame_error, exp_fe);
      check("data_byte", data_byte, exp_byte);
      if (data_valid === 1'b1) begin
        n_dv++;
        last_dv_cyc    = cyc;
        busy_at_dv     = busy;
        busy_before_dv = prev_busy;
      end
      if (frame_error === 1'b1) n_fe++;
    end
    prev_busy = busy;
  end

  // ---------------- stimulus helpers ----------------
  // All helpers start and end aligned at 1 time unit after a rising edge.
  task automatic drive(input bit v, input int ncyc);
    rx_line = v;
    repeat (ncyc) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input int p, input bit stop, output int n);
    n = cyc;
    exq.push_back(predict(n, d, stop, p));
    drive(1'b0, p);
    for (int k = 0; k < 8; k++) drive(d[k], p);
    drive(stop, p);
  endtask

  task automatic wait_neg(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    #(10 * 80000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n2, dv0, fe0;
    logic [7:0] lb [5];
    rst_n   = 1'b0;
    rx_line = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data_byte", data_byte, 8'h00);
    check("rst_data_valid", data_valid, 1'b0);
    check("rst_frame_error", frame_error, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    drive(1'b1, 50);

    // Single frame, exact rate; absolute latency pinned to 3+43+9*86 = 820.
    dv0 = n_dv; fe0 = n_fe;
    send(8'hA5, 86, 1'b1, n);
    drive(1'b1, 100);
    check("a5_pulses", n_dv - dv0, 1);
    check("a5_latency", last_dv_cyc - n, 820);
    check("a5_byte", data_byte, 8'hA5);
    check("a5_busy_at_pulse", busy_at_dv, 1'b0);
    check("a5_busy_before_pulse", busy_before_dv, 1'b1);
    check("a5_no_fe", n_fe - fe0, 0);

    // Back-to-back with a slow (87-cycle) transmitter and zero gap.
    dv0 = n_dv;
    send(8'h00, 87, 1'b1, n);
    send(8'hFF, 87, 1'b1, n2);
    drive(1'b1, 100);
    check("b2b_pulses", n_dv - dv0, 2);
    check("b2b_byte", data_byte, 8'hFF);
    check("b2b_latency2", last_dv_cyc - n2, 820);

    // 20-cycle glitch: false start rejected at the START sample.
    dv0 = n_dv; fe0 = n_fe;
    n = cyc;
    drive(1'b0, 20);
    rx_line = 1'b1;
    wait_neg(n + HALF + 2);
    check("glitch_busy_start", busy, 1'b1);
    wait_neg(n + HALF + 3);
    check("glitch_busy_idle", busy, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 100);
    check("glitch_no_pulse", (n_dv - dv0) + (n_fe - fe0), 0);
    send(8'h3C, 86, 1'b1, n);
    drive(1'b1, 50);
    check("glitch_next_byte", data_byte, 8'h3C);

    // Bad stop bit followed by a held-low break.
    dv0 = n_dv; fe0 = n_fe;
    send(8'h5A, 86, 1'b0, n);
    drive(1'b0, 5 * CPB);
    drive(1'b1, 200);
    check("break_fe_pulses", n_fe - fe0, 1);
    check("break_dv_pulses", n_dv - dv0, 0);
    check("break_byte_held", data_byte, 8'h3C);

    // Reset during data bit 4 aborts the frame; the line is released with it.
    dv0 = n_dv; fe0 = n_fe;
    drive(1'b0, 86);
    for (int k = 0; k < 4; k++) drive(k[0], 86);
    drive(1'b0, 43);
    rst_n   = 1'b0;
    rx_line = 1'b1;
    rst_cyc = cyc + 1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1'b1, 100);
    check("abort_no_pulse", (n_dv - dv0) + (n_fe - fe0), 0);
    check("abort_byte_reset", data_byte, 8'h00);
    send(8'hC3, 86, 1'b1, n);
    drive(1'b1, 50);
    check("abort_next_byte", data_byte, 8'hC3);

    // Transmitter-style stream at the nominal rate.
    fe0 = n_fe; dv0 = n_dv;
    lb[0] = 8'h00; lb[1] = 8'h55; lb[2] = 8'hAA; lb[3] = 8'hFF; lb[4] = 8'h81;
    foreach (lb[i]) send(lb[i], 86, 1'b1, n);
    drive(1'b1, 50);
    check("stream_pulses", n_dv - dv0, 5);
    check("stream_no_fe", n_fe - fe0, 0);
    check("stream_last_byte", data_byte, 8'h81);

    // Randomised frames: byte, rate, stop bit, hold time and gap.
    for (int i = 0; i < 12; i++) begin
      logic [7:0] d;
      int p;
      bit stop;
      d    = 8'($urandom_range(0, 255));
      p    = $urandom_range(86, 87);
      stop = ($urandom_range(0, 4) != 0);
      send(d, p, stop, n);
      if (!stop) begin
        drive(1'b0, $urandom_range(0, 100));
        drive(1'b1, $urandom_range(2, 30));
      end else begin
        drive(1'b1, $urandom_range(0, 30));
      end
    end

    drive(1'b1, 1000);
    check("all_expected_seen", exq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
